bin_to_bcd_scheduler: RTL and testbench

BIN_TO_BCD_SCHEDULER -- requirements
Module: bin_to_bcd_scheduler

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_shift_engine.sv | 58 +++++
 rtl/bin_to_bcd_scheduler.sv | 104 ++++++++++
 tb/tb_bin_to_bcd_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared encodings and double-dabble constants for the binary-to-BCD scheduler.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADD3_OFFSET    = 4'd3;

endpackage

// File: rtl/bcd_shift_engine.sv
// Serial double-dabble engine: one add-3/shift step per cycle while step is high.
module bcd_shift_engine
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    localparam int N     = DIGITS * 4,
    localparam int CW    = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] operand,
    input  logic         step,
    output logic         done,
    output logic [N-1:0] bcd,
    output logic         ovf
);

    logic [N-1:0]  bin_q;
    logic [N-1:0]  bcd_q;
    logic          ovf_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  adj;

    // bcd/ovf present the value after the current step, so the final step's
    // result can be captured on the same edge that retires it.
    always_comb begin
        adj = bcd_q;
        for (int j = 0; j < DIGITS; j++) begin
            if (bcd_q[j*4 +: 4] >= ADD3_THRESHOLD)
                adj[j*4 +: 4] = bcd_q[j*4 +: 4] + ADD3_OFFSET;
        end
    end

    assign bcd  = {adj[N-2:0], bin_q[N-1]};
    assign ovf  = ovf_q | adj[N-1];
    assign done = step && (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            bin_q <= operand;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (step) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd;
            ovf_q <= ovf;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bin_to_bcd_scheduler.sv
// Round-robin arbiter feeding a shared serial binary-to-BCD converter.
// Handshakes: a transfer happens in any cycle where valid and ready are both high.
module bin_to_bcd_scheduler
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int N_REQ  = 2,
    localparam int N     = DIGITS * 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*N-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_bcd,
    output logic [IDW-1:0]     out_id,
    output logic               out_ovf,
    output logic               busy
);

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   job_id_q;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    int               grant_idx;
    logic             found;
    logic             hs;
    logic             eng_done;
    logic [N-1:0]     eng_bcd;
    logic             eng_ovf;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_idx = 0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign hs        = |req_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    bcd_shift_engine #(.DIGITS(DIGITS)) u_engine (
        .clk     (clk),
        .rst     (rst),
        .load    (hs),
        .operand (req_data[grant_idx*N +: N]),
        .step    (state_q == CONV),
        .done    (eng_done),
        .bcd     (eng_bcd),
        .ovf     (eng_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            job_id_q <= '0;
            out_bcd  <= '0;
            out_id   <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        job_id_q <= grant_id;
                        ptr_q    <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    if (eng_done) begin
                        out_bcd <= eng_bcd;
                        out_ovf <= eng_ovf;
                        out_id  <= job_id_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_scheduler.sv
// Directed bench for bin_to_bcd_scheduler with DIGITS=4, N_REQ=2.
module tb_bin_to_bcd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [0:0]  out_id;
    logic        out_ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_scheduler #(.DIGITS(4), .N_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_id    (out_id),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (sampling on negedges) until a grant is visible; returns cycles waited.
    task automatic wait_grant(output int n);
        n = 0;
        while (req_ready == 2'b00 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 2'b00) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic run_one(input int k, input logic [15:0] data,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        int cyc;
        @(posedge clk); #1;
        req_valid    = 2'b00;
        req_valid[k] = 1'b1;
        req_data[k*16 +: 16] = data;
        @(negedge clk);
        chk("grant", req_ready, 32'(1 << k));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("conv_busy", busy, 1);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 17);
        chk("bcd", out_bcd, exp_bcd);
        chk("id", out_id, k);
        chk("ovf", out_ovf, exp_ovf);
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_busy", busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 2'b11; req_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bcd", out_bcd, 0);
        @(posedge clk); #1;
        req_valid = 2'b00; rst = 1'b0;

        // Single requests and boundary operands
        run_one(0, 16'h04D2, 16'h1234, 1'b0);
        run_one(1, 16'h002A, 16'h0042, 1'b0);
        run_one(0, 16'd9999, 16'h9999, 1'b0);
        run_one(1, 16'd10000, 16'h0000, 1'b1);
        run_one(0, 16'd65535, 16'h5535, 1'b1);
        run_one(0, 16'd0, 16'h0000, 1'b0);

        // Backpressure: pointer is at 1 here, requester 1 gets 255
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_data  = {16'd255, 16'd1};
        req_valid = 2'b10;
        @(negedge clk);
        wait_grant(n);
        chk("bp_grant", req_ready, 32'b10);
        @(posedge clk); #1;
        req_valid = 2'b01;
        wait_result(n);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_bcd", out_bcd, 16'h0255);
            chk("bp_id", out_id, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", out_valid, 0);
        chk("bp_hold_bcd", out_bcd, 16'h0255);
        chk("bp_hold_id", out_id, 1);
        chk("bp_next_grant", req_ready, 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_result(n);
        chk("bp_next_bcd", out_bcd, 16'h0001);
        chk("bp_next_id", out_id, 0);

        // Reset in CONV cycle 8; pointer is at 1 before the reset
        @(posedge clk); #1;
        req_data  = {16'h0000, 16'h1234};
        req_valid = 2'b01;
        @(negedge clk);
        chk("mid_grant", req_ready, 32'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        rst       = 1'b1;
        req_data  = {16'h0063, 16'h0007};
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_bcd", out_bcd, 0);
        chk("mid_id", out_id, 0);
        chk("mid_ovf", out_ovf, 0);

        // Fairness: both valid continuously, requester 0 first after reset
        for (int r = 0; r < 4; r++) begin
            wait_grant(n);
            chk("fair_grant", req_ready, 32'(1 << (r % 2)));
            if (r > 0) chk("fair_spacing", n, 18 - 17);
            wait_result(n);
            chk("fair_latency", n, 17);
            chk("fair_id", out_id, r % 2);
            chk("fair_bcd", out_bcd, (r % 2 == 0) ? 32'h0007 : 32'h0099);
            chk("fair_ovf", out_ovf, 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
